// File: rtl/display_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | display_sequencer : bomb-game FSM, countdown timer and OLED pixel pipe.  |
// | Define DISPLAY_SEQUENCER_BLINK_EN for a blinking BOOM screen. Rev 1.0    |
// +--------------------------------------------------------------------------+
module display_sequencer #(
  parameter int COUNT_SECONDS  = 30,
  parameter int FRAMES_PER_SEC = 60
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_begin,
  input  logic [12:0] pixel_index,
  input  logic        btn_start,
  input  logic [4:0]  wire_sw,
  input  logic [2:0]  correct_wire,
  input  logic [15:0] start_data,
  input  logic [15:0] game_data,
  input  logic [15:0] boom_data,
  input  logic [15:0] defused_data,
  output logic [6:0]  x,
  output logic [5:0]  y,
  output logic [15:0] oled_data,
  output logic [2:0]  state,
  output logic [6:0]  seconds_left
);

  localparam int            FW         = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_SEC - 1);
  localparam logic [6:0]    SEC_INIT   = 7'(COUNT_SECONDS);

  typedef enum logic [2:0] {
    S_START   = 3'd0,
    S_ARM     = 3'd1,
    S_RUN     = 3'd2,
    S_BOOM    = 3'd3,
    S_DEFUSED = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [6:0]    sec_q, sec_d;
  logic [FW-1:0] frame_q, frame_d;
  logic [2:0]    corr_q, corr_d;
  logic          btn_q;
  logic [4:0]    wire_q;
  logic          primed_q;
  logic [6:0]    x_q;
  logic [5:0]    y_q;
  logic [15:0]   oled_q, oled_d;
  logic [15:0]   boom_disp;
  logic          btn_rise;
  logic [4:0]    wire_rise;

  // Edges are masked on the first clk after reset so a held button is not a press.
  assign btn_rise  = primed_q & btn_start & ~btn_q;
  assign wire_rise = primed_q ? (wire_sw & ~wire_q) : 5'b00000;

  always_comb begin
    state_d = state_q;
    sec_d   = sec_q;
    frame_d = frame_q;
    corr_d  = corr_q;
    case (state_q)
      S_START: begin
        if (btn_rise) state_d = S_ARM;
      end
      S_ARM: begin
        if (wire_sw == 5'b00000) begin
          state_d = S_RUN;
          sec_d   = SEC_INIT;
          frame_d = '0;
          corr_d  = correct_wire;
        end
      end
      S_RUN: begin
        if (sec_q == 7'd0) begin
          state_d = S_BOOM;
        end else if (wire_rise != 5'b00000) begin
          // An out-of-range latched index shifts to zero, so any cut detonates.
          state_d = (wire_rise == (5'b00001 << corr_q)) ? S_DEFUSED : S_BOOM;
        end else if (frame_begin) begin
          if (frame_q == FRAME_LAST) begin
            frame_d = '0;
            sec_d   = sec_q - 7'd1;
          end else begin
            frame_d = frame_q + 1'b1;
          end
        end
      end
      S_BOOM, S_DEFUSED: begin
        if (btn_rise) begin
          state_d = S_START;
          sec_d   = SEC_INIT;
        end
      end
      default: begin
        state_d = S_START;
        sec_d   = SEC_INIT;
      end
    endcase
  end

`ifdef DISPLAY_SEQUENCER_BLINK_EN
  logic [3:0] blink_q, blink_d;

  always_comb begin
    blink_d = 4'd0;
    if (state_q == S_BOOM) blink_d = frame_begin ? blink_q + 4'd1 : blink_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) blink_q <= 4'd0;
    else        blink_q <= blink_d;
  end

  assign boom_disp = blink_q[3] ? ~boom_data : boom_data;
`else
  assign boom_disp = boom_data;
`endif

  always_comb begin
    oled_d = start_data;
    case (state_q)
      S_RUN:     oled_d = game_data;
      S_BOOM:    oled_d = boom_disp;
      S_DEFUSED: oled_d = defused_data;
      default:   oled_d = start_data;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_START;
      sec_q    <= SEC_INIT;
      frame_q  <= '0;
      corr_q   <= 3'd0;
      btn_q    <= 1'b0;
      wire_q   <= 5'b00000;
      primed_q <= 1'b0;
      x_q      <= 7'd0;
      y_q      <= 6'd0;
      oled_q   <= 16'd0;
    end else begin
      state_q  <= state_d;
      sec_q    <= sec_d;
      frame_q  <= frame_d;
      corr_q   <= corr_d;
      btn_q    <= btn_start;
      wire_q   <= wire_sw;
      primed_q <= 1'b1;
      x_q      <= 7'(pixel_index % 13'd96);
      y_q      <= 6'(pixel_index / 13'd96);
      oled_q   <= oled_d;
    end
  end

  assign x            = x_q;
  assign y            = y_q;
  assign oled_data    = oled_q;
  assign state        = state_q;
  assign seconds_left = sec_q;

endmodule
`default_nettype wire
